// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with pending-write scoreboard.
package regfile_pkg;

    localparam int WIDTH  = 32;
    localparam int NREGS  = 16;
    localparam int AW     = 4;
    localparam int PC_IDX = 15;
    localparam int LR_IDX = 14;

    typedef logic [AW-1:0]    reg_addr_t;
    typedef logic [WIDTH-1:0] reg_data_t;

    // True for addresses backed by real storage (in range and not the PC alias).
    function automatic logic addr_stored(input reg_addr_t a);
        return (int'(a) < NREGS) && (int'(a) != PC_IDX);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-side bundle of the register file: read ports, two write ports, issue/hazard.
interface regfile_sb_if #(parameter int NRD = 3);
    import regfile_pkg::*;

    logic [NRD*AW-1:0]    ra;
    logic [NRD-1:0]       rd_en;
    logic [NRD*WIDTH-1:0] rd;
    reg_data_t            pc_in;
    logic                 we_a;
    reg_addr_t            wa_a;
    reg_data_t            wd_a;
    logic                 we_b;
    reg_addr_t            wa_b;
    reg_data_t            wd_b;
    logic                 issue_en;
    reg_addr_t            issue_dst;
    logic                 flush;
    logic                 issue_rdy;
    logic [NRD-1:0]       hazard;

    modport master (
        output ra, rd_en, pc_in, we_a, wa_a, wd_a, we_b, wa_b, wd_b,
               issue_en, issue_dst, flush,
        input  rd, issue_rdy, hazard
    );

    modport slave (
        input  ra, rd_en, pc_in, we_a, wa_a, wd_a, we_b, wa_b, wd_b,
               issue_en, issue_dst, flush,
        output rd, issue_rdy, hazard
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register saturating pending-write counters; drives issue_rdy and per-port RAW hazard flags.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NRD  = 3,
    parameter int CNTW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_en_i,
    input  reg_addr_t         issue_dst_i,
    input  logic              flush_i,
    input  logic              we_a_i,
    input  reg_addr_t         wa_a_i,
    input  logic [NRD*AW-1:0] ra_i,
    input  logic [NRD-1:0]    rd_en_i,
    output logic              issue_rdy_o,
    output logic [NRD-1:0]    hazard_o
);

    localparam int              NSLOT   = 1 << AW;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [CNTW-1:0] cnt_q [NSLOT];
    logic [CNTW-1:0] cnt_d [NSLOT];
    logic            dec_s;
    logic            inc_s;

    // Port B (link) never retires a tracked destination, so only port A decrements.
    assign dec_s       = we_a_i && addr_stored(wa_a_i) && (cnt_q[wa_a_i] != {CNTW{1'b0}});
    assign issue_rdy_o = !addr_stored(issue_dst_i)
                      || (cnt_q[issue_dst_i] != CNT_MAX)
                      || (dec_s && (wa_a_i == issue_dst_i));
    assign inc_s       = issue_en_i && issue_rdy_o && addr_stored(issue_dst_i);

    always_comb begin
        for (int r = 0; r < NSLOT; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush_i) begin
                cnt_d[r] = {CNTW{1'b0}};
            end else if (inc_s && (issue_dst_i == reg_addr_t'(r))
                         && !(dec_s && (wa_a_i == reg_addr_t'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNTW'(1);
            end else if (dec_s && (wa_a_i == reg_addr_t'(r))
                         && !(inc_s && (issue_dst_i == reg_addr_t'(r)))) begin
                cnt_d[r] = cnt_q[r] - CNTW'(1);
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NSLOT; r++) begin
                cnt_q[r] <= {CNTW{1'b0}};
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A last pending write retiring this cycle is covered by the read bypass, so no hazard.
    always_comb begin
        hazard_o = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            hazard_o[i] = rd_en_i[i]
                && addr_stored(ra_i[i*AW +: AW])
                && (cnt_q[ra_i[i*AW +: AW]] != {CNTW{1'b0}})
                && !((cnt_q[ra_i[i*AW +: AW]] == CNTW'(1)) && dec_s
                     && (wa_a_i == ra_i[i*AW +: AW]));
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with PC alias, write-through read bypass and a pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int NRD  = 3,
    parameter int CNTW = 2
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);

    reg_data_t            stored_s [NREGS];
    logic [NRD*WIDTH-1:0] rd_s;

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        if (r == PC_IDX) begin : g_pc
            assign stored_s[r] = {WIDTH{1'b0}};
        end else begin : g_store
            reg_data_t mem_q;
            reg_data_t mem_d;

            // Port B (link) takes priority when both ports target this register.
            always_comb begin
                mem_d = mem_q;
                if (bus.we_b && (bus.wa_b == reg_addr_t'(r))) begin
                    mem_d = bus.wd_b;
                end else if (bus.we_a && (bus.wa_a == reg_addr_t'(r))) begin
                    mem_d = bus.wd_a;
                end else begin
                    mem_d = mem_q;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_q <= {WIDTH{1'b0}};
                end else begin
                    mem_q <= mem_d;
                end
            end

            assign stored_s[r] = mem_q;
        end
    end

    always_comb begin
        rd_s = {(NRD*WIDTH){1'b0}};
        for (int i = 0; i < NRD; i++) begin
            if (int'(bus.ra[i*AW +: AW]) == PC_IDX) begin
                rd_s[i*WIDTH +: WIDTH] = bus.pc_in;
            end else if (int'(bus.ra[i*AW +: AW]) >= NREGS) begin
                rd_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end else if (bus.we_b && (bus.wa_b == bus.ra[i*AW +: AW])) begin
                rd_s[i*WIDTH +: WIDTH] = bus.wd_b;
            end else if (bus.we_a && (bus.wa_a == bus.ra[i*AW +: AW])) begin
                rd_s[i*WIDTH +: WIDTH] = bus.wd_a;
            end else begin
                rd_s[i*WIDTH +: WIDTH] = stored_s[bus.ra[i*AW +: AW]];
            end
        end
    end

    assign bus.rd = rd_s;

    regfile_scoreboard #(
        .NRD  (NRD),
        .CNTW (CNTW)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .issue_en_i  (bus.issue_en),
        .issue_dst_i (bus.issue_dst),
        .flush_i     (bus.flush),
        .we_a_i      (bus.we_a),
        .wa_a_i      (bus.wa_a),
        .ra_i        (bus.ra),
        .rd_en_i     (bus.rd_en),
        .issue_rdy_o (bus.issue_rdy),
        .hazard_o    (bus.hazard)
    );

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the processor register file. It provides NRD combinational read ports and two write ports: port A for ALU/load writeback and port B for the link write. The PC-alias register returns an external PC value. A per-register pending-write scoreboard (saturating counters) lets the pipelined core detect RAW hazards. It sits between decode (read/issue) and writeback.

Parameters:
WIDTH, 32, data width of every register
NREGS, 16, architectural registers (index 0..NREGS-1)
AW, 4, address width, must satisfy 2**AW >= NREGS
NRD, 3, number of read ports
PC_IDX, 15, index that aliases the PC input; not stored
CNTW, 2, pending-counter width per register (max 2**CNTW-1 outstanding writes)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous active-high reset
ra  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
rd_en  in  NRD  read port i is in use (qualifies hazard only)
rd  out  NRD*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
pc_in  in  WIDTH  value returned for reads of PC_IDX (PC+8)
we_a  in  1  write enable, port A
wa_a  in  AW  write address, port A
wd_a  in  WIDTH  write data, port A
we_b  in  1  write enable, port B (link)
wa_b  in  AW  write address, port B
wd_b  in  WIDTH  write data, port B
issue_en  in  1  instruction with destination is issuing this cycle
issue_dst  in  AW  its destination register
flush  in  1  discard all outstanding pending writes
issue_rdy  out  1  issue_dst counter can accept another increment
hazard  out  NRD  port i reads a register with an uncleared pending write

Behaviour:
- Reset (async, active-high): all stored registers = 0, all counters = 0. With reset held, rd = 0 for non-PC addresses and pc_in for PC_IDX; hazard = 0; issue_rdy = 1.
- Storage: NREGS-1 entries. PC_IDX has no storage.
- Writes at posedge. If both ports write the same address, port B wins. Writes to PC_IDX or to an address >= NREGS are ignored.
- Reads are combinational, zero latency:
  - ra == PC_IDX -> pc_in.
  - Otherwise, write-through bypass: if we_b and wa_b == ra -> wd_b; else if we_a and wa_a == ra -> wd_a; else the stored value.
  - ra >= NREGS -> 0.
- Scoreboard: per-register counter cnt[r], CNTW bits.
  - inc = issue_en and issue_rdy and issue_dst != PC_IDX.
  - dec = we_a and wa_a != PC_IDX and cnt[wa_a] != 0. Port B never touches the scoreboard.
  - Same register incremented and decremented in one cycle: cnt unchanged.
  - Decrement at 0 is ignored (no underflow).
  - Increment at max is blocked by issue_rdy.
- issue_rdy = (cnt[issue_dst] != max) or (a decrement of issue_dst this cycle). It is combinational. issue_rdy = 1 when issue_dst == PC_IDX.
- hazard[i] = rd_en[i] and ra[i] != PC_IDX and cnt[ra[i]] != 0, and not (cnt[ra[i]] == 1 and a decrement of ra[i] this cycle). The bypass supplies the final value in that last case.
- flush: at the next edge all cnt = 0. It overrides any inc/dec that cycle. Register writes in the same cycle still occur.
- Reset mid-operation: all state clears immediately. Outputs follow from the cleared state plus the current inputs.

Decomposition:
- Shared package (regfile_pkg):
  - constants WIDTH, NREGS, AW, PC_IDX, LR_IDX = 14
  - typedef reg_addr_t (logic [AW-1:0])
  - typedef reg_data_t (logic [WIDTH-1:0])
- One sub-module, regfile_scoreboard: the counters, inc/dec/flush logic, issue_rdy, hazard. The data array, bypass and PC alias stay in regfile_sb.

Test Plan:
- Reset, then read all addresses 0..14 with pc_in = 0x0000_1008 -> 0 for 0..14, 0x0000_1008 for 15. hazard = 0, issue_rdy = 1.
- we_a = 1, wa_a = 3, wd_a = 0xDEAD_BEEF with ra[0] = 3 in the same cycle -> rd[0] = 0xDEAD_BEEF combinationally (bypass) and again after the edge. Write wa_a = 15 -> read of 15 still returns pc_in.
- we_a (wa 14, 0x1111) and we_b (wa 14, 0x2222) in the same cycle -> r14 = 0x2222 after the edge.
- Issue dst 5 three times (CNTW = 2) -> cnt = 3, issue_rdy = 0 for dst 5. hazard[1] = 1 with ra[1] = 5, rd_en[1] = 1. Issue dst 5 while we_a writes r5 -> issue accepted, cnt stays 3.
- cnt[7] = 1, we_a writes r7 = 0x42 while ra[0] = 7 -> hazard[0] = 0, rd[0] = 0x42. Next cycle cnt[7] = 0.
- cnt[2] = 2 and cnt[9] = 1, assert flush together with issue_en dst 2 -> all counters 0 next cycle, hazard = 0. Then assert reset mid-write -> r3 reads 0 immediately.
